// File: rtl/inference_run_monitor.sv
// Run monitor for MLP inference programs. It snoops the register-file write port
// for exit, image-progress and correct-count writes and judges the run.
module inference_run_monitor #(
  parameter int unsigned DWidth        = 32,
  parameter int unsigned NumOfTest     = 1000,
  parameter int unsigned ExitReg       = 25,
  parameter int unsigned ExitCode      = 99999,
  parameter int unsigned ImgReg        = 26,
  parameter int unsigned CorrReg       = 27,
  parameter int unsigned CntWidth      = 64,
  parameter int unsigned TimeoutCycles = 2000000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                rf_we_i,
  input  logic [4:0]          rf_waddr_i,
  input  logic [DWidth-1:0]   rf_wdata_i,
  input  logic                retire_i,
  output logic [1:0]          state_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic                pass_o,
  output logic                seq_err_o,
  output logic [DWidth-1:0]   image_cnt_o,
  output logic [DWidth-1:0]   correct_cnt_o,
  output logic [CntWidth-1:0] cycle_cnt_o,
  output logic [CntWidth-1:0] instret_cnt_o,
  output logic [DWidth-1:0]   img_lat_last_o,
  output logic [DWidth-1:0]   img_lat_max_o,
  output logic                progress_o
);

  // Watchdog only has to reach TimeoutCycles-1, so it never wraps.
  localparam int unsigned WdW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [WdW-1:0]      WdLast   = WdW'(TimeoutCycles - 1);
  localparam logic [4:0]          ExitAddr = 5'(ExitReg);
  localparam logic [4:0]          ImgAddr  = 5'(ImgReg);
  localparam logic [4:0]          CorrAddr = 5'(CorrReg);
  localparam logic [DWidth-1:0]   ExitVal  = DWidth'(ExitCode);
  localparam logic [DWidth-1:0]   NumTest  = DWidth'(NumOfTest);
  localparam logic [DWidth-1:0]   DOne     = DWidth'(1);
  localparam logic [CntWidth-1:0] COne     = CntWidth'(1);
  localparam logic [WdW-1:0]      WOne     = WdW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DWidth-1:0]   image_cnt_q, image_cnt_d;
  logic [DWidth-1:0]   correct_cnt_q, correct_cnt_d;
  logic [CntWidth-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CntWidth-1:0] instret_q, instret_d;
  logic [DWidth-1:0]   lat_acc_q, lat_acc_d;
  logic [DWidth-1:0]   lat_last_q, lat_last_d;
  logic [DWidth-1:0]   lat_max_q, lat_max_d;
  logic [WdW-1:0]      wdog_q, wdog_d;
  logic                seq_err_q, seq_err_d;
  logic                progress_q, progress_d;

  logic              snoop, img_wr, corr_wr, exit_wr, wd_exp;
  logic              img_bad, corr_bad;
  logic [DWidth-1:0] lat_now;
  logic [DWidth:0]   corr_lim;

  // Snoops only count in RUN; a restart pulse takes precedence over them.
  assign snoop   = rf_we_i && (rf_waddr_i != 5'd0) && (state_q == S_RUN) && !start_i;
  assign img_wr  = snoop && (rf_waddr_i == ImgAddr) && (rf_wdata_i != '0);
  assign corr_wr = snoop && (rf_waddr_i == CorrAddr);
  assign exit_wr = snoop && (rf_waddr_i == ExitAddr) && (rf_wdata_i == ExitVal);
  assign wd_exp  = (state_q == S_RUN) && !start_i && (wdog_q == WdLast) && !img_wr;

  assign lat_now  = lat_acc_q + DOne;
  assign img_bad  = (rf_wdata_i != (image_cnt_q + DOne)) || (rf_wdata_i > NumTest);
  // Extra bit keeps the +1 bound from wrapping at the top of the range.
  assign corr_lim = {1'b0, correct_cnt_q} + (DWidth+1)'(1);
  assign corr_bad = (rf_wdata_i < correct_cnt_q) || ({1'b0, rf_wdata_i} > corr_lim);

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (exit_wr)     state_d = S_DONE;
          else if (wd_exp) state_d = S_TIMEOUT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    image_cnt_d   = image_cnt_q;
    correct_cnt_d = correct_cnt_q;
    cycle_cnt_d   = cycle_cnt_q;
    instret_d     = instret_q;
    lat_acc_d     = lat_acc_q;
    lat_last_d    = lat_last_q;
    lat_max_d     = lat_max_q;
    wdog_d        = wdog_q;
    seq_err_d     = seq_err_q;
    progress_d    = 1'b0;
    if (start_i) begin
      image_cnt_d   = '0;
      correct_cnt_d = '0;
      cycle_cnt_d   = '0;
      instret_d     = '0;
      lat_acc_d     = '0;
      lat_last_d    = '0;
      lat_max_d     = '0;
      wdog_d        = '0;
      seq_err_d     = 1'b0;
    end else if (state_q == S_RUN) begin
      cycle_cnt_d = cycle_cnt_q + COne;
      instret_d   = instret_q + CntWidth'(retire_i);
      lat_acc_d   = lat_now;
      wdog_d      = wdog_q + WOne;
      if (img_wr) begin
        image_cnt_d = rf_wdata_i;
        progress_d  = 1'b1;
        lat_last_d  = lat_now;
        if (lat_now > lat_max_q) lat_max_d = lat_now;
        lat_acc_d   = '0;
        wdog_d      = '0;
        if (img_bad) seq_err_d = 1'b1;
      end
      if (corr_wr) begin
        correct_cnt_d = rf_wdata_i;
        if (corr_bad) seq_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      image_cnt_q   <= '0;
      correct_cnt_q <= '0;
      cycle_cnt_q   <= '0;
      instret_q     <= '0;
      lat_acc_q     <= '0;
      lat_last_q    <= '0;
      lat_max_q     <= '0;
      wdog_q        <= '0;
      seq_err_q     <= 1'b0;
      progress_q    <= 1'b0;
    end else begin
      image_cnt_q   <= image_cnt_d;
      correct_cnt_q <= correct_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_q     <= instret_d;
      lat_acc_q     <= lat_acc_d;
      lat_last_q    <= lat_last_d;
      lat_max_q     <= lat_max_d;
      wdog_q        <= wdog_d;
      seq_err_q     <= seq_err_d;
      progress_q    <= progress_d;
    end
  end

  assign state_o        = state_q;
  assign done_o         = (state_q == S_DONE);
  assign timeout_o      = (state_q == S_TIMEOUT);
  assign pass_o         = (state_q == S_DONE) && (image_cnt_q == NumTest) &&
                          !seq_err_q && (correct_cnt_q <= NumTest);
  assign seq_err_o      = seq_err_q;
  assign image_cnt_o    = image_cnt_q;
  assign correct_cnt_o  = correct_cnt_q;
  assign cycle_cnt_o    = cycle_cnt_q;
  assign instret_cnt_o  = instret_q;
  assign img_lat_last_o = lat_last_q;
  assign img_lat_max_o  = lat_max_q;
  assign progress_o     = progress_q;

endmodule

// File: tb/tb_inference_run_monitor.sv
// Bench for inference_run_monitor: two instances (long and short watchdog) checked
// each cycle against a timestamp-based model, plus directed scenario checks.
module tb_inference_run_monitor;

  logic        clk;
  logic        rst_i, start_i, rf_we_i, retire_i;
  logic [4:0]  rf_waddr_i;
  logic [31:0] rf_wdata_i;

  logic [1:0]  st_w    [2];
  logic        done_w  [2];
  logic        to_w    [2];
  logic        pass_w  [2];
  logic        seq_w   [2];
  logic [31:0] img_w   [2];
  logic [31:0] corr_w  [2];
  logic [63:0] cyc_w   [2];
  logic [63:0] inst_w  [2];
  logic [31:0] last_w  [2];
  logic [31:0] max_w   [2];
  logic        prog_w  [2];

  inference_run_monitor #(.NumOfTest(3), .TimeoutCycles(1000)) u_a (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .rf_we_i(rf_we_i),
    .rf_waddr_i(rf_waddr_i), .rf_wdata_i(rf_wdata_i), .retire_i(retire_i),
    .state_o(st_w[0]), .done_o(done_w[0]), .timeout_o(to_w[0]), .pass_o(pass_w[0]),
    .seq_err_o(seq_w[0]), .image_cnt_o(img_w[0]), .correct_cnt_o(corr_w[0]),
    .cycle_cnt_o(cyc_w[0]), .instret_cnt_o(inst_w[0]), .img_lat_last_o(last_w[0]),
    .img_lat_max_o(max_w[0]), .progress_o(prog_w[0]));

  inference_run_monitor #(.NumOfTest(3), .TimeoutCycles(50)) u_b (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .rf_we_i(rf_we_i),
    .rf_waddr_i(rf_waddr_i), .rf_wdata_i(rf_wdata_i), .retire_i(retire_i),
    .state_o(st_w[1]), .done_o(done_w[1]), .timeout_o(to_w[1]), .pass_o(pass_w[1]),
    .seq_err_o(seq_w[1]), .image_cnt_o(img_w[1]), .correct_cnt_o(corr_w[1]),
    .cycle_cnt_o(cyc_w[1]), .instret_cnt_o(inst_w[1]), .img_lat_last_o(last_w[1]),
    .img_lat_max_o(max_w[1]), .progress_o(prog_w[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: run phase 0=IDLE 1=RUN 2=DONE 3=TIMEOUT; times are edge numbers.
  typedef struct {
    int          st;
    logic [31:0] img, corr, last, max;
    bit          seq, prog;
    longint      t0, mark, cyc;
    logic [63:0] inst;
  } mdl_t;

  mdl_t   m [2];
  longint to_c [2];
  longint now;
  int     n_chk, n_err;
  bit     rand_ret;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, now, obs, exp);
    end
  endtask

  function automatic mdl_t mdl_clear();
    mdl_t r;
    r.st = 0; r.img = '0; r.corr = '0; r.last = '0; r.max = '0;
    r.seq = 1'b0; r.prog = 1'b0; r.t0 = 0; r.mark = 0; r.cyc = 0; r.inst = '0;
    return r;
  endfunction

  task automatic mdl_step(input int k);
    mdl_t r;
    bit   snoop, iw;
    r = m[k];
    if (rst_i) begin
      r = mdl_clear();
    end else if (start_i) begin
      r = mdl_clear();
      r.st = 1; r.t0 = now; r.mark = now;
    end else if (r.st == 1) begin
      r.prog = 1'b0;
      snoop = rf_we_i && (rf_waddr_i != 0);
      iw = snoop && (rf_waddr_i == 26) && (rf_wdata_i != 0);
      r.inst = r.inst + 64'(retire_i);
      if (iw) begin
        r.last = 32'(now - r.mark);
        if (r.last > r.max) r.max = r.last;
        r.mark = now;
        if (rf_wdata_i != 32'(r.img + 1) || rf_wdata_i > 3) r.seq = 1'b1;
        r.img = rf_wdata_i;
        r.prog = 1'b1;
      end
      if (snoop && rf_waddr_i == 27) begin
        if (longint'(rf_wdata_i) < longint'(r.corr) ||
            longint'(rf_wdata_i) > longint'(r.corr) + 1) r.seq = 1'b1;
        r.corr = rf_wdata_i;
      end
      if (snoop && rf_waddr_i == 25 && rf_wdata_i == 99999) begin
        r.st = 2; r.cyc = now - r.t0;
      end else if (!iw && (now - r.mark) == to_c[k]) begin
        r.st = 3; r.cyc = now - r.t0;
      end
    end else begin
      r.prog = 1'b0;
    end
    m[k] = r;
  endtask

  task automatic cmp_all(input int k);
    logic [63:0] ecyc;
    bit          epass;
    ecyc  = (m[k].st == 1) ? 64'(now - m[k].t0) : 64'(m[k].cyc);
    epass = (m[k].st == 2) && (m[k].img == 3) && !m[k].seq && (m[k].corr <= 3);
    chk($sformatf("state%0d", k),   64'(st_w[k]),   64'(m[k].st));
    chk($sformatf("done%0d", k),    64'(done_w[k]), 64'(m[k].st == 2));
    chk($sformatf("timeout%0d", k), 64'(to_w[k]),   64'(m[k].st == 3));
    chk($sformatf("pass%0d", k),    64'(pass_w[k]), 64'(epass));
    chk($sformatf("seq%0d", k),     64'(seq_w[k]),  64'(m[k].seq));
    chk($sformatf("img%0d", k),     64'(img_w[k]),  64'(m[k].img));
    chk($sformatf("corr%0d", k),    64'(corr_w[k]), 64'(m[k].corr));
    chk($sformatf("cyc%0d", k),     cyc_w[k],       ecyc);
    chk($sformatf("inst%0d", k),    inst_w[k],      m[k].inst);
    chk($sformatf("last%0d", k),    64'(last_w[k]), 64'(m[k].last));
    chk($sformatf("max%0d", k),     64'(max_w[k]),  64'(m[k].max));
    chk($sformatf("prog%0d", k),    64'(prog_w[k]), 64'(m[k].prog));
  endtask

  task automatic tick();
    @(posedge clk);
    now++;
    mdl_step(0);
    mdl_step(1);
    #1;
    cmp_all(0);
    cmp_all(1);
    rst_i = 1'b0; start_i = 1'b0; rf_we_i = 1'b0;
    rf_waddr_i = 5'($urandom); rf_wdata_i = $urandom;
    if (rand_ret) retire_i = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rf_we_i = 1'b1; rf_waddr_i = a; rf_wdata_i = d;
    tick();
  endtask

  task automatic go();
    start_i = 1'b1;
    tick();
  endtask

  initial begin
    n_chk = 0; n_err = 0; now = 0; rand_ret = 1'b1;
    to_c[0] = 1000; to_c[1] = 50;
    m[0] = mdl_clear(); m[1] = mdl_clear();
    rst_i = 1'b1; start_i = 1'b0; rf_we_i = 1'b0; retire_i = 1'b0;
    rf_waddr_i = '0; rf_wdata_i = '0;
    tick();
    rst_i = 1'b1;
    tick();
    chk("rst_state", 64'(st_w[0]), 64'd0);
    chk("rst_cyc", cyc_w[0], 64'd0);

    // nominal run, images every 100 cycles
    go();
    idle(99);  wr(5'd26, 32'd1); wr(5'd27, 32'd1);
    idle(98);  wr(5'd26, 32'd2); wr(5'd27, 32'd2);
    idle(98);  wr(5'd26, 32'd3); wr(5'd27, 32'd2);
    wr(5'd25, 32'd99999);
    chk("nom_done", 64'(done_w[0]), 64'd1);
    chk("nom_pass", 64'(pass_w[0]), 64'd1);
    chk("nom_img", 64'(img_w[0]), 64'd3);
    chk("nom_corr", 64'(corr_w[0]), 64'd2);
    chk("nom_last", 64'(last_w[0]), 64'd100);
    chk("nom_max", 64'(max_w[0]), 64'd100);
    chk("nom_cyc", cyc_w[0], 64'd302);
    idle(10);
    chk("nom_cyc_frozen", cyc_w[0], 64'd302);

    // sequence error
    go();
    wr(5'd26, 32'd1); wr(5'd26, 32'd3);
    chk("seq_err", 64'(seq_w[0]), 64'd1);
    chk("seq_img", 64'(img_w[0]), 64'd3);
    wr(5'd25, 32'd99999);
    chk("seq_done", 64'(done_w[0]), 64'd1);
    chk("seq_pass", 64'(pass_w[0]), 64'd0);

    // watchdog on the short-timeout instance
    go();
    idle(49);
    chk("wd_run", 64'(st_w[1]), 64'd1);
    tick();
    chk("wd_state", 64'(st_w[1]), 64'd3);
    chk("wd_flag", 64'(to_w[1]), 64'd1);
    chk("wd_cyc", cyc_w[1], 64'd50);

    // exit in the expiry cycle
    go();
    idle(49);
    wr(5'd25, 32'd99999);
    chk("sim_done", 64'(done_w[1]), 64'd1);
    chk("sim_to", 64'(to_w[1]), 64'd0);

    // ignored writes
    go();
    wr(5'd25, 32'd5); wr(5'd26, 32'd0); wr(5'd0, 32'd99999);
    chk("ign_state", 64'(st_w[0]), 64'd1);
    chk("ign_seq", 64'(seq_w[0]), 64'd0);
    chk("ign_img", 64'(img_w[0]), 64'd0);

    // reset mid-run, then a fresh run with known retirements
    go();
    wr(5'd26, 32'd1); idle(3); wr(5'd26, 32'd2);
    chk("mid_img", 64'(img_w[0]), 64'd2);
    rst_i = 1'b1;
    tick();
    chk("mid_rst_state", 64'(st_w[0]), 64'd0);
    chk("mid_rst_img", 64'(img_w[0]), 64'd0);
    chk("mid_rst_max", 64'(max_w[0]), 64'd0);
    chk("mid_rst_inst", inst_w[0], 64'd0);
    rand_ret = 1'b0; retire_i = 1'b1;
    go();
    idle(5);
    chk("fresh_img", 64'(img_w[0]), 64'd0);
    chk("fresh_inst", inst_w[0], 64'd5);
    rand_ret = 1'b1;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(99));
      if (r < 2) start_i = 1'b1;
      else if (r == 2 && $urandom_range(9) == 0) rst_i = 1'b1;
      else if (r < 25) begin
        rf_we_i = 1'b1;
        case ($urandom_range(4))
          0: rf_waddr_i = 5'd0;
          1: begin
            rf_waddr_i = 5'd25;
            rf_wdata_i = ($urandom_range(14) == 0) ? 32'd99999 : 32'($urandom_range(9));
          end
          2: begin
            rf_waddr_i = 5'd26;
            case ($urandom_range(9))
              7:       rf_wdata_i = 32'd0;
              8, 9:    rf_wdata_i = 32'($urandom_range(5));
              default: rf_wdata_i = m[0].img + 32'd1;
            endcase
          end
          3: begin
            rf_waddr_i = 5'd27;
            rf_wdata_i = ($urandom_range(4) == 0) ? 32'($urandom_range(5))
                                                   : m[0].corr + 32'($urandom_range(1));
          end
          default: ;
        endcase
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/inference_run_monitor.md
Name: inference_run_monitor

Overview:
- Synthesizable run monitor for the scalar core's MLP inference programs.
- Snoops the register-file write port and decodes the software protocol:
  - exit sentinel written to the exit register;
  - image index written to the image register;
  - correct count written to the correction register.
- Keeps 64-bit cycle and retired-instruction counters, per-image latency statistics, a progress watchdog and a sequence checker.
- Sits beside CPU_TOP, so long runs can be judged on silicon or FPGA without a testbench probing internal GPRs.

Parameters:
- DWidth, 32, register write-data width.
- NumOfTest, 1000, expected number of inferred images.
- ExitReg, 25, GPR index carrying the exit sentinel.
- ExitCode, 99999, sentinel value that ends a run.
- ImgReg, 26, GPR index carrying the completed-image count.
- CorrReg, 27, GPR index carrying the running correct count.
- CntWidth, 64, width of the cycle and instret counters.
- TimeoutCycles, 2000000, maximum cycles allowed between image-register writes.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  single-cycle arm/restart pulse.
- rf_we_i  in  1  register-file write enable.
- rf_waddr_i  in  5  register-file write address.
- rf_wdata_i  in  DWidth  register-file write data.
- retire_i  in  1  one instruction retired this cycle.
- state_o  out  2  0=IDLE, 1=RUN, 2=DONE, 3=TIMEOUT.
- done_o  out  1  run ended by exit sentinel.
- timeout_o  out  1  run ended by watchdog.
- pass_o  out  1  DONE with image_cnt==NumOfTest, no seq_err, correct_cnt<=NumOfTest.
- seq_err_o  out  1  sticky protocol violation.
- image_cnt_o  out  DWidth  last accepted image count.
- correct_cnt_o  out  DWidth  last value written to CorrReg.
- cycle_cnt_o  out  CntWidth  cycles spent in RUN.
- instret_cnt_o  out  CntWidth  retirements counted in RUN.
- img_lat_last_o  out  DWidth  cycles taken by the most recent image.
- img_lat_max_o  out  DWidth  largest per-image latency.
- progress_o  out  1  one-cycle pulse per accepted image write.

Behaviour:
- rst_i is sampled at a clock edge. All outputs are 0 and state is IDLE one cycle after rst_i is high. Reset mid-RUN discards everything.
- IDLE:
  - Snoops are ignored.
  - start_i clears all counters and flags and moves to RUN on the next cycle.
- RUN, every cycle:
  - cycle_cnt += 1, lat_acc += 1, wdog += 1.
  - instret_cnt += retire_i.
  - All counters wrap modulo 2^width with no saturation.
- Snoop decode applies only when rf_we_i=1 and rf_waddr_i != 0. Outputs update one cycle after the write cycle.
- Write to ImgReg with data D:
  - D==0: ignored, since it is the software init value.
  - Otherwise: accept D as the new image_cnt_o and pulse progress_o.
  - img_lat_last = lat_acc + 1 (counts the write cycle itself).
  - img_lat_max = max(img_lat_max, that value).
  - lat_acc and wdog clear to 0.
  - Set seq_err if D != image_cnt_o + 1 or D > NumOfTest.
- Write to CorrReg with data D:
  - correct_cnt_o = D.
  - Set seq_err if D decreases by more than zero or increases by more than 1 from its previous value.
- Write to ExitReg with data == ExitCode: move to DONE, done_o=1. Any other value written to ExitReg is ignored.
- Watchdog: when wdog reaches TimeoutCycles-1 with no image write that cycle, move to TIMEOUT and set timeout_o=1.
- Simultaneous events in the same cycle:
  - Exit beats timeout.
  - An image write in the exit cycle is still accepted.
  - start_i during RUN restarts the run (clear, stay in RUN).
- DONE / TIMEOUT:
  - All counters are frozen and snoops are ignored.
  - pass_o is evaluated combinationally from frozen values and is only ever 1 in DONE.
  - start_i re-arms to RUN with counters cleared.
- seq_err_o is sticky until start_i or rst_i.

Test Plan:
- Nominal run: rst, start. Write ImgReg 1..3 at 100-cycle intervals, CorrReg 1,2,2, then ExitReg=99999. Use NumOfTest=3.
  - Expect done_o=1, pass_o=1, image_cnt=3, correct_cnt=2.
  - Expect img_lat_last=100 and img_lat_max=100.
  - Expect cycle_cnt equal to the exact RUN cycle count, frozen thereafter.
- Sequence error: write ImgReg 1, then 3.
  - Expect seq_err_o=1 and image_cnt=3.
  - Exit still gives done_o=1 with pass_o=0.
- Watchdog: TimeoutCycles=50, start, no writes.
  - Expect state=TIMEOUT exactly 50 cycles after RUN entry, timeout_o=1, cycle_cnt=50.
- Simultaneous events: exit write in the same cycle the watchdog expires.
  - Expect DONE and timeout_o=0.
- Non-sentinel and zero writes: ExitReg=5, ImgReg=0, write to x0.
  - Expect no state change and no seq_err.
- Reset mid-RUN after 2 images, then start.
  - Expect all outputs 0 after reset and a fresh RUN with image_cnt=0.
  - instret counts only retire_i pulses issued after the new start.
